// File: rtl/rsa_pkg.sv
// Shared constants for the RSA datapath: default width, control levels and
// the 4-bit state encodings of the exponentiation controller.
package rsa_pkg;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam logic        START_LVL      = 1'b1;
    localparam logic        RESET_LVL      = 1'b0;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CHECK    = 4'd1;
    localparam logic [3:0] S_RED_ISS  = 4'd2;
    localparam logic [3:0] S_RED_WAIT = 4'd3;
    localparam logic [3:0] S_SQ_ISS   = 4'd4;
    localparam logic [3:0] S_SQ_WAIT  = 4'd5;
    localparam logic [3:0] S_MUL_ISS  = 4'd6;
    localparam logic [3:0] S_MUL_WAIT = 4'd7;
    localparam logic [3:0] S_NEXT     = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;
    localparam logic [3:0] S_ERROR    = 4'd10;
endpackage

// File: rtl/rsa_core_mul.sv
// Registered W x W -> 2W unsigned multiplier; the product register is the
// dividend presented to the reduction core and only changes on i_load.
module rsa_core_mul
    import rsa_pkg::*;
#(
    parameter int W = DATA_WIDTH_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_load,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);
    logic [2*W-1:0] w_prod;

    assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

    always_ff @(posedge i_clk) begin
        if (i_rst_n == RESET_LVL) begin
            o_p <= '0;
        end else if (i_load) begin
            o_p <= w_prod;
        end
    end
endmodule

// File: rtl/rsa_core_modexp.sv
// Left-to-right square-and-multiply controller: exp_c = exp_base^exp_exp mod exp_n,
// with every reduction delegated to an attached rsa_core_mod over the mod_* handshake.
module rsa_core_modexp
    import rsa_pkg::*;
#(
    parameter int   DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic START      = START_LVL
) (
    input  logic                    exp_clk,
    input  logic                    exp_rst,
    input  logic                    exp_start,
    input  logic [DATA_WIDTH-1:0]   exp_base,
    input  logic [DATA_WIDTH-1:0]   exp_exp,
    input  logic [DATA_WIDTH-1:0]   exp_n,
    output logic                    exp_done,
    output logic                    exp_err,
    output logic [DATA_WIDTH-1:0]   exp_c,
    output logic                    mod_start,
    output logic [2*DATA_WIDTH-1:0] mod_a,
    output logic [DATA_WIDTH-1:0]   mod_b,
    input  logic                    mod_done,
    input  logic                    mod_err,
    input  logic [DATA_WIDTH-1:0]   mod_c
);
    localparam int W  = DATA_WIDTH;
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic [3:0]    r_state;
    logic [W-1:0]  r_base;
    logic [W-1:0]  r_exp;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_r;
    logic [IW-1:0] r_idx;

    logic          w_mul_load;
    logic [W-1:0]  w_mul_a;
    logic [W-1:0]  w_mul_b;
    logic          w_ok;

    assign w_ok = mod_done && !mod_err;

    // The product is loaded on the edge that enters an ISS state, so the operands
    // are chosen from the values that edge would otherwise be capturing.
    always_comb begin
        w_mul_load = 1'b0;
        w_mul_a    = r_r;
        w_mul_b    = r_r;
        case (r_state)
            S_CHECK: begin
                w_mul_load = (mod_b != '0);
                w_mul_a    = r_base;
                w_mul_b    = W'(1);
            end
            S_RED_WAIT: w_mul_load = w_ok;
            S_SQ_WAIT: begin
                w_mul_load = w_ok && r_exp[r_idx];
                w_mul_a    = mod_c;
                w_mul_b    = r_b;
            end
            S_NEXT:  w_mul_load = (r_idx != '0);
            default: w_mul_load = 1'b0;
        endcase
    end

    rsa_core_mul #(.W(W)) u_mul (
        .i_clk   (exp_clk),
        .i_rst_n (exp_rst),
        .i_load  (w_mul_load),
        .i_a     (w_mul_a),
        .i_b     (w_mul_b),
        .o_p     (mod_a)
    );

    always_ff @(posedge exp_clk) begin
        if (exp_rst == RESET_LVL) begin
            r_state   <= S_IDLE;
            exp_done  <= 1'b0;
            exp_err   <= 1'b0;
            exp_c     <= '0;
            mod_start <= 1'b0;
            mod_b     <= '0;
            r_base    <= '0;
            r_exp     <= '0;
            r_b       <= '0;
            r_r       <= '0;
            r_idx     <= '0;
        end else begin
            exp_done  <= 1'b0;
            mod_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (exp_start == START) begin
                        r_base  <= exp_base;
                        r_exp   <= exp_exp;
                        mod_b   <= exp_n;
                        r_r     <= W'(1);
                        r_idx   <= IW'(W - 1);
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mod_b == '0) begin
                        r_state <= S_ERROR;
                    end else begin
                        mod_start <= 1'b1;
                        r_state   <= S_RED_ISS;
                    end
                end
                S_RED_ISS: r_state <= S_RED_WAIT;
                S_RED_WAIT: begin
                    if (mod_done) begin
                        if (mod_err) begin
                            r_state <= S_ERROR;
                        end else begin
                            r_b       <= mod_c;
                            mod_start <= 1'b1;
                            r_state   <= S_SQ_ISS;
                        end
                    end
                end
                S_SQ_ISS: r_state <= S_SQ_WAIT;
                S_SQ_WAIT: begin
                    if (mod_done) begin
                        if (mod_err) begin
                            r_state <= S_ERROR;
                        end else begin
                            r_r <= mod_c;
                            if (r_exp[r_idx]) begin
                                mod_start <= 1'b1;
                                r_state   <= S_MUL_ISS;
                            end else begin
                                r_state <= S_NEXT;
                            end
                        end
                    end
                end
                S_MUL_ISS: r_state <= S_MUL_WAIT;
                S_MUL_WAIT: begin
                    if (mod_done) begin
                        if (mod_err) begin
                            r_state <= S_ERROR;
                        end else begin
                            r_r     <= mod_c;
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (r_idx == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx     <= r_idx - 1'b1;
                        mod_start <= 1'b1;
                        r_state   <= S_SQ_ISS;
                    end
                end
                S_DONE: begin
                    exp_c    <= r_r;
                    exp_err  <= 1'b0;
                    exp_done <= 1'b1;
                    r_state  <= S_IDLE;
                end
                S_ERROR: begin
                    exp_c    <= '1;
                    exp_err  <= 1'b1;
                    exp_done <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_core_modexp.sv
// Bench for rsa_core_modexp: a behavioural reduction responder with random latency
// and error injection, checked against plain repeated-multiplication arithmetic.
module tb_rsa_core_modexp;
    localparam int W = 8;

    logic           exp_clk   = 1'b0;
    logic           exp_rst   = 1'b0;
    logic           exp_start = 1'b0;
    logic [W-1:0]   exp_base  = '0;
    logic [W-1:0]   exp_exp   = '0;
    logic [W-1:0]   exp_n     = '0;
    logic           exp_done;
    logic           exp_err;
    logic [W-1:0]   exp_c;
    logic           mod_start;
    logic [2*W-1:0] mod_a;
    logic [W-1:0]   mod_b;
    logic           mod_done  = 1'b0;
    logic           mod_err   = 1'b0;
    logic [W-1:0]   mod_c     = '0;

    int errors = 0;
    int checks = 0;

    int             pulses    = 0;
    int             resp_n    = 0;
    int             inject_at = -1;
    int             max_a     = 0;
    logic [W-1:0]   cur_n     = '0;
    bit             rsp_busy  = 1'b0;
    int             rsp_wait  = 0;
    logic [2*W-1:0] rsp_a     = '0;
    logic [W-1:0]   rsp_b     = '0;

    rsa_core_modexp #(.DATA_WIDTH(W), .START(1'b1)) dut (
        .exp_clk   (exp_clk),
        .exp_rst   (exp_rst),
        .exp_start (exp_start),
        .exp_base  (exp_base),
        .exp_exp   (exp_exp),
        .exp_n     (exp_n),
        .exp_done  (exp_done),
        .exp_err   (exp_err),
        .exp_c     (exp_c),
        .mod_start (mod_start),
        .mod_a     (mod_a),
        .mod_b     (mod_b),
        .mod_done  (mod_done),
        .mod_err   (mod_err),
        .mod_c     (mod_c)
    );

    always #5 exp_clk = ~exp_clk;

    task automatic check_val(input string tag, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
        end
    endtask

    // Reduction responder, acting just after each rising edge.
    always @(posedge exp_clk) begin
        #1;
        mod_done = 1'b0;
        mod_err  = 1'b0;
        if (exp_rst == 1'b0) begin
            rsp_busy = 1'b0;
        end else if (mod_start) begin
            pulses++;
            rsp_a    = mod_a;
            rsp_b    = mod_b;
            rsp_busy = 1'b1;
            rsp_wait = int'($urandom_range(0, 3));
            if (int'(mod_a) > max_a) max_a = int'(mod_a);
            check_val("mod_b", mod_b, cur_n);
        end else if (rsp_busy) begin
            if (rsp_wait == 0) begin
                resp_n++;
                mod_done = 1'b1;
                mod_err  = (rsp_b == '0) || (resp_n == inject_at);
                mod_c    = (rsp_b == '0) ? '1 : W'(rsp_a % rsp_b);
                rsp_busy = 1'b0;
            end else begin
                rsp_wait--;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                          input int inj, input int hold);
        longint   want_c;
        bit       want_err;
        int       want_p;
        int       p0;
        int       cyc;
        bit       seen;
        logic [W-1:0] got_c;
        logic     got_err;
        got_c   = '0;
        got_err = 1'b0;
        if (n == 0) begin
            want_c = 255; want_err = 1'b1; want_p = 0;
        end else if (inj > 0) begin
            want_c = 255; want_err = 1'b1; want_p = inj;
        end else begin
            want_c = 1 % n;
            for (int k = 0; k < int'(e); k++) want_c = (want_c * b) % n;
            want_err = 1'b0;
            want_p   = 1 + W + $countones(e);
        end
        inject_at = (inj > 0) ? resp_n + inj : -1;
        @(negedge exp_clk);
        exp_base = b; exp_exp = e; exp_n = n; cur_n = n;
        exp_start = 1'b1;
        p0 = pulses; cyc = 0; seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge exp_clk);
            cyc++;
            if (cyc >= hold) exp_start = 1'b0;
            if (exp_done) begin
                seen = 1'b1; got_c = exp_c; got_err = exp_err;
            end
        end
        exp_start = 1'b0;
        check_val("done_seen", seen, 1);
        if (seen) begin
            check_val("exp_c", got_c, want_c);
            check_val("exp_err", got_err, want_err);
            check_val("pulses", pulses - p0, want_p);
            if (n == 0) check_val("err_latency", cyc, 3);
            @(negedge exp_clk);
            check_val("done_width", exp_done, 0);
            check_val("c_hold", exp_c, got_c);
        end
        $display("op base=%0d e=%0d n=%0d inj=%0d -> c=%0d err=%0d pulses=%0d cycles=%0d",
                 b, e, n, inj, got_c, got_err, pulses - p0, cyc);
        inject_at = -1;
    endtask

    initial begin
        int p0;
        int cyc;
        repeat (3) @(negedge exp_clk);
        exp_rst = 1'b1;
        @(negedge exp_clk);
        check_val("rst_done", exp_done, 0);
        check_val("rst_err", exp_err, 0);
        check_val("rst_c", exp_c, 0);
        check_val("rst_mod_start", mod_start, 0);
        check_val("rst_mod_a", mod_a, 0);
        check_val("rst_mod_b", mod_b, 0);

        run_op(8'd7,   8'd5,   8'd13,  0, 1);
        run_op(8'd200, 8'd0,   8'd77,  0, 1);
        run_op(8'd5,   8'd3,   8'd1,   0, 1);
        run_op(8'd255, 8'd255, 8'd251, 0, 1);
        check_val("max_mod_a_ok", (max_a <= 32'hFE01) ? 1 : 0, 1);
        run_op(8'd9,   8'd9,   8'd0,   0, 1);
        run_op(8'd7,   8'd5,   8'd13,  3, 1);
        run_op(8'd7,   8'd5,   8'd13,  0, 1);

        // Reset pulse while the first squaring is outstanding.
        @(negedge exp_clk);
        exp_base = 8'd7; exp_exp = 8'd5; exp_n = 8'd13; cur_n = 8'd13;
        exp_start = 1'b1;
        p0 = pulses;
        @(negedge exp_clk);
        exp_start = 1'b0;
        cyc = 0;
        while (pulses < p0 + 2 && cyc < 500) begin
            @(negedge exp_clk);
            cyc++;
        end
        check_val("rst_wait_ok", (cyc < 500) ? 1 : 0, 1);
        @(negedge exp_clk);
        exp_rst = 1'b0;
        @(negedge exp_clk);
        exp_rst = 1'b1;
        check_val("midrst_done", exp_done, 0);
        check_val("midrst_err", exp_err, 0);
        check_val("midrst_c", exp_c, 0);
        check_val("midrst_mod_start", mod_start, 0);
        check_val("midrst_mod_a", mod_a, 0);
        check_val("midrst_mod_b", mod_b, 0);
        p0 = pulses;
        repeat (6) @(negedge exp_clk);
        check_val("midrst_idle", pulses - p0, 0);
        $display("op mid-request reset -> outputs cleared, idle");

        run_op(8'd7, 8'd5, 8'd13, 0, 15);
        run_op(8'd7, 8'd5, 8'd13, 0, 1);

        for (int t = 0; t < 12; t++) begin
            run_op(W'($urandom), W'($urandom), W'($urandom_range(0, 255)), 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
